if_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register for the MIPS core.
- Owns the PC and issues requests to instruction memory over a req/ready handshake.
- Presents the fetched word and its PC+4 to decode, including opCode/funct to the control decoder.
- Consumes the decoder's exception flag and the downstream branch/jump redirect; redirects the PC and flushes IF/ID.

---
 rtl/if_stage.sv | 170 +++++++++++++++++
 tb/tb_if_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC and issues word fetches over a req/ready handshake. A
// one-entry skid buffer catches a word that returns while decode is
// stalled. Redirects and exceptions flush IF/ID. A request that is still
// in flight when the PC is redirected is drained and its data is dropped.
module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] EXCP_VECTOR = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        excp,
  output logic [31:0] epc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic [5:0]  opCode,
  output logic [5:0]  funct
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // normal fetching
    HOLD  = 2'd1,  // skid buffer full, waiting for stall to drop
    DRAIN = 2'd2   // discard one stale response after a redirect
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        outstanding_q, outstanding_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;

  logic [31:0] fetch_pc4;
  logic        pending;

  // Request side: an accepted-but-unanswered request keeps its address stable.
  always_comb begin
    imem_addr = outstanding_q ? addr_q : pc_q;
    imem_req  = !reset &&
                (((state_q == FETCH) && (!stall || outstanding_q)) ||
                 (state_q == DRAIN));
    fetch_pc4 = imem_addr + 32'd4;
    // A request is still in flight after this edge.
    pending   = imem_req && !imem_ready;
  end

  // Next-state logic: redirects (exception first) win over normal fetch flow.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    outstanding_d = outstanding_q;
    if_id_valid_d = if_id_valid_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    epc_d         = epc_q;
    skid_instr_d  = skid_instr_q;
    skid_pc4_d    = skid_pc4_q;

    // Handshake bookkeeping is independent of what happens to the data.
    if (imem_ready) begin
      outstanding_d = 1'b0;
    end else if (imem_req) begin
      outstanding_d = 1'b1;
      if (!outstanding_q) begin
        addr_d = pc_q;
      end
    end

    if (excp || redirect_valid) begin
      if (excp) begin
        epc_d = if_id_pc4_q - 32'd4;
        pc_d  = EXCP_VECTOR;
      end else begin
        pc_d  = {redirect_pc[31:2], 2'b00};
      end
      if_id_valid_d = 1'b0;
      if_id_instr_d = 32'h0;
      skid_instr_d  = 32'h0;
      skid_pc4_d    = 32'h0;
      state_d       = pending ? DRAIN : FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready) begin
            pc_d = fetch_pc4;
            if (!stall) begin
              if_id_valid_d = 1'b1;
              if_id_instr_d = imem_rdata;
              if_id_pc4_d   = fetch_pc4;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc4_d   = fetch_pc4;
              state_d      = HOLD;
            end
          end else if (!stall) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = 32'h0;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = skid_instr_q;
            if_id_pc4_d   = skid_pc4_q;
            state_d       = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ready) begin
            state_d = FETCH;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      addr_q        <= 32'h0;
      outstanding_q <= 1'b0;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= 32'h0;
      if_id_pc4_q   <= 32'h0;
      epc_q         <= 32'h0;
      skid_instr_q  <= 32'h0;
      skid_pc4_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      outstanding_q <= outstanding_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      epc_q         <= epc_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc4_q    <= skid_pc4_d;
    end
  end

  // Decode-facing outputs; opCode/funct read as a nop when IF/ID is empty.
  always_comb begin
    epc         = epc_q;
    if_id_valid = if_id_valid_q;
    if_id_instr = if_id_instr_q;
    if_id_pc4   = if_id_pc4_q;
    opCode      = if_id_instr_q[31:26];
    funct       = if_id_instr_q[5:0];
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: instruction memory responses are driven by
// hand, and every expected value is a hand-computed constant.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        excp;
  logic [31:0] epc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [5:0]  opCode;
  logic [5:0]  funct;

  int n_checks;
  int n_errors;

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .excp           (excp),
    .epc            (epc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4),
    .opCode         (opCode),
    .funct          (funct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word for an address: tag in the middle, funct 6'b111111.
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hA000_0000 | (a << 8) | 32'h0000_003F;
  endfunction

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t req=%0b addr=%h ifid_v=%0b instr=%h pc4=%h epc=%h",
             $time, imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc4, epc);
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; excp = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_errors++; $display("FAIL reset_req: got %0b expected 0", imem_req);
    end
    step();
    step();
    n_checks++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_ifid: got v=%0b i=%h p=%h expected 0/0/0", if_id_valid, if_id_instr, if_id_pc4);
    end
    n_checks++;
    if (epc !== 32'h0 || opCode !== 6'h0 || funct !== 6'h0) begin
      n_errors++; $display("FAIL reset_epc_dec: got epc=%h op=%h fn=%h expected 0", epc, opCode, funct);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_errors++; $display("FAIL reset_first_req: got req=%0b addr=%h expected 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    imem_ready = 1'b1; imem_rdata = word(32'h0);
    step();
    n_checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== 32'hA000_003F || if_id_pc4 !== 32'h4) begin
      n_errors++;
      $display("FAIL stream_w0: got v=%0b i=%h p=%h expected 1/a000003f/4", if_id_valid, if_id_instr, if_id_pc4);
    end
    n_checks++;
    if (imem_addr !== 32'h4) begin
      n_errors++; $display("FAIL stream_addr4: got %h expected 00000004", imem_addr);
    end
    imem_rdata = word(32'h4);
    step();
    n_checks++;
    if (if_id_pc4 !== 32'h8 || imem_addr !== 32'h8 || if_id_instr !== 32'hA000_043F) begin
      n_errors++;
      $display("FAIL stream_w4: got p=%h a=%h i=%h expected 8/8/a000043f", if_id_pc4, imem_addr, if_id_instr);
    end
  endtask

  task automatic test_wait();
    imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
        n_errors++;
        $display("FAIL wait_cycle%0d: got req=%0b a=%h v=%0b i=%h expected 1/8/0/0",
                 i, imem_req, imem_addr, if_id_valid, if_id_instr);
      end
    end
    imem_ready = 1'b1; imem_rdata = word(32'h8);
    step();
    n_checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== 32'hA000_083F || if_id_pc4 !== 32'hC || imem_addr !== 32'hC) begin
      n_errors++;
      $display("FAIL wait_deliver: got v=%0b i=%h p=%h a=%h expected 1/a000083f/c/c",
               if_id_valid, if_id_instr, if_id_pc4, imem_addr);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1; imem_ready = 1'b1; imem_rdata = word(32'hC);
    step();
    imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (if_id_instr !== 32'hA000_083F || if_id_pc4 !== 32'hC || imem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_hold: got i=%h p=%h req=%0b expected a000083f/c/0", if_id_instr, if_id_pc4, imem_req);
    end
    step();
    stall = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || if_id_instr !== 32'hA000_083F) begin
      n_errors++; $display("FAIL stall_hold_unstall: got req=%0b i=%h expected 0/a000083f", imem_req, if_id_instr);
    end
    step();
    n_checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== 32'hA000_0C3F || if_id_pc4 !== 32'h10) begin
      n_errors++;
      $display("FAIL stall_release: got v=%0b i=%h p=%h expected 1/a0000c3f/10", if_id_valid, if_id_instr, if_id_pc4);
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      n_errors++; $display("FAIL stall_next_req: got req=%0b a=%h expected 1/10", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect();
    imem_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
    step();
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10 || if_id_valid !== 1'b0) begin
      n_errors++; $display("FAIL redir_drain: got req=%0b a=%h v=%0b expected 1/10/0", imem_req, imem_addr, if_id_valid);
    end
    imem_ready = 1'b1; imem_rdata = word(32'h10);
    step();
    n_checks++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || imem_addr !== 32'h40 || imem_req !== 1'b1) begin
      n_errors++;
      $display("FAIL redir_dropped: got v=%0b i=%h a=%h req=%0b expected 0/0/40/1",
               if_id_valid, if_id_instr, imem_addr, imem_req);
    end
    imem_rdata = word(32'h40);
    step();
    n_checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== 32'hA000_403F || if_id_pc4 !== 32'h44) begin
      n_errors++;
      $display("FAIL redir_target: got v=%0b i=%h p=%h expected 1/a000403f/44", if_id_valid, if_id_instr, if_id_pc4);
    end
  endtask

  task automatic test_excp();
    // Jump to 0x20 with no request in flight, then fetch that word.
    stall = 1'b1; imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0; stall = 1'b0; imem_ready = 1'b1; imem_rdata = word(32'h20);
    step();
    n_checks++;
    if (if_id_pc4 !== 32'h24 || funct !== 6'h3F || opCode !== 6'h28) begin
      n_errors++; $display("FAIL excp_setup: got p=%h fn=%h op=%h expected 24/3f/28", if_id_pc4, funct, opCode);
    end
    excp = 1'b1; imem_rdata = word(32'h24);
    step();
    excp = 1'b0;
    #1;
    n_checks++;
    if (epc !== 32'h20) begin
      n_errors++; $display("FAIL excp_epc: got %h expected 00000020", epc);
    end
    n_checks++;
    if (imem_addr !== 32'h180 || imem_req !== 1'b1 || if_id_valid !== 1'b0 || opCode !== 6'h0 || funct !== 6'h0) begin
      n_errors++;
      $display("FAIL excp_vector: got a=%h req=%0b v=%0b op=%h fn=%h expected 180/1/0/0/0",
               imem_addr, imem_req, if_id_valid, opCode, funct);
    end
  endtask

  task automatic test_priority_and_reset();
    imem_ready = 1'b1; imem_rdata = word(32'h180);
    step();
    n_checks++;
    if (if_id_instr !== 32'hA001_803F || if_id_pc4 !== 32'h184) begin
      n_errors++; $display("FAIL prio_setup: got i=%h p=%h expected a001803f/184", if_id_instr, if_id_pc4);
    end
    excp = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300; imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    step();
    excp = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1;
    n_checks++;
    if (epc !== 32'h180 || imem_addr !== 32'h184 || imem_req !== 1'b1 || if_id_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL prio_drain: got epc=%h a=%h req=%0b v=%0b expected 180/184/1/0",
               epc, imem_addr, imem_req, if_id_valid);
    end
    // Reset while draining abandons the request.
    reset = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_errors++; $display("FAIL drain_reset_req: got %0b expected 0", imem_req);
    end
    step();
    reset = 1'b0;
    #1;
    n_checks++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1 || if_id_valid !== 1'b0 || epc !== 32'h0) begin
      n_errors++;
      $display("FAIL drain_reset_state: got a=%h req=%0b v=%0b epc=%h expected 0/1/0/0",
               imem_addr, imem_req, if_id_valid, epc);
    end
    imem_ready = 1'b1; imem_rdata = word(32'h0);
    step();
    n_checks++;
    if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h4) begin
      n_errors++; $display("FAIL drain_reset_fetch: got v=%0b p=%h expected 1/4", if_id_valid, if_id_pc4);
    end
  endtask

  task automatic test_wrap();
    stall = 1'b1; imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    stall = 1'b0;
    #1;
    n_checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      n_errors++; $display("FAIL wrap_target: got %h expected fffffffc", imem_addr);
    end
    imem_ready = 1'b1; imem_rdata = word(32'hFFFF_FFFC);
    step();
    n_checks++;
    if (if_id_pc4 !== 32'h0 || imem_addr !== 32'h0 || if_id_instr !== 32'hFFFF_FC3F) begin
      n_errors++;
      $display("FAIL wrap_pc4: got p=%h a=%h i=%h expected 0/0/fffffc3f", if_id_pc4, imem_addr, if_id_instr);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_redirect();
    test_excp();
    test_priority_and_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
